// File: rtl/sram_port_arbiter_pkg.sv
// Shared encodings for the fetch/data SRAM port arbiter: grant owner,
// response-ownership FSM states and the d_we read constant.
package sram_port_arbiter_pkg;

   localparam int WE_W = 4;

   // All-zero byte enables mark a data read
   localparam logic [WE_W-1:0] WE_READ = '0;

   typedef enum logic [1:0] {
      OWN_NONE  = 2'd0,
      OWN_FETCH = 2'd1,
      OWN_DATA  = 2'd2
   } grant_owner_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      I_RESP = 2'd1,
      D_RESP = 2'd2
   } resp_state_e;

   function automatic logic is_read(input logic [WE_W-1:0] we);
      return we == WE_READ;
   endfunction

endpackage

// File: rtl/sram_port_arbiter_starve_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module starve_counter #(
   parameter int MAX = 4,
   parameter int W   = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (inc_i && (cnt_q != W'(MAX)))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/sram_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-port SRAM with
// 1-cycle read latency; data has priority until fetch has waited STARVE_MAX grants.
module sram_port_arbiter
   import sram_port_arbiter_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_gnt,
   output logic              i_rvalid,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic [WE_W-1:0]   d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              m_en,
   output logic [WE_W-1:0]   m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic [DATA_W-1:0] m_rdata
);

   localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

   logic [CNT_W-1:0] starve_cnt;
   logic             fetch_pri;
   grant_owner_e     owner;
   resp_state_e      state_q;
   logic [DATA_W-1:0] i_hold_q, d_hold_q;

   assign fetch_pri = (starve_cnt == CNT_W'(STARVE_MAX));

   // Grants are suppressed while reset is asserted so every output reads 0
   always_comb begin
      owner = OWN_NONE;
      if (!reset) begin
         if (i_req && (!d_req || fetch_pri)) owner = OWN_FETCH;
         else if (d_req)                     owner = OWN_DATA;
      end
   end

   assign i_gnt = (owner == OWN_FETCH);
   assign d_gnt = (owner == OWN_DATA);

   always_comb begin
      m_en    = 1'b0;
      m_we    = '0;
      m_addr  = '0;
      m_wdata = '0;
      case (owner)
         OWN_FETCH: begin
            m_en   = 1'b1;
            m_addr = i_addr;
         end
         OWN_DATA: begin
            m_en    = 1'b1;
            m_we    = d_we;
            m_addr  = d_addr;
            m_wdata = d_wdata;
         end
         default: ;
      endcase
   end

   starve_counter #(
      .MAX (STARVE_MAX),
      .W   (CNT_W)
   ) u_starve (
      .clk   (clk),
      .reset (reset),
      .clr_i (i_gnt | ~i_req),
      .inc_i (d_gnt & i_req),
      .cnt_o (starve_cnt)
   );

   // Response owner for the next cycle; writes complete at the grant edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         i_hold_q <= '0;
         d_hold_q <= '0;
      end else begin
         if (state_q == I_RESP) i_hold_q <= m_rdata;
         if (state_q == D_RESP) d_hold_q <= m_rdata;
         case (owner)
            OWN_FETCH: state_q <= I_RESP;
            OWN_DATA:  state_q <= is_read(d_we) ? D_RESP : IDLE;
            default:   state_q <= IDLE;
         endcase
      end
   end

   assign i_rvalid = (state_q == I_RESP);
   assign d_rvalid = (state_q == D_RESP);
   assign i_rdata  = i_rvalid ? m_rdata : i_hold_q;
   assign d_rdata  = d_rvalid ? m_rdata : d_hold_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: vector table plus response scoreboard against
// a bench-side SRAM model and reference memory.
module tb_sram_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_req, d_req;
   logic [31:0] i_addr, d_addr, d_wdata;
   logic [3:0]  d_we;
   logic        i_gnt, i_rvalid, d_gnt, d_rvalid;
   logic [31:0] i_rdata, d_rdata;
   logic        m_en;
   logic [3:0]  m_we;
   logic [31:0] m_addr, m_wdata;
   logic [31:0] m_rdata = 32'h0;

   always #5 clk = ~clk;

   sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
   );

   // SRAM model: byte-enabled write, 1-cycle synchronous read
   logic [31:0] mem     [0:255];
   logic [31:0] ref_mem [0:255];

   always @(posedge clk) begin
      if (m_en) begin
         if (m_we != 4'h0) begin
            for (int b = 0; b < 4; b++)
               if (m_we[b]) mem[m_addr[9:2]][8*b +: 8] <= m_wdata[8*b +: 8];
         end else begin
            m_rdata <= mem[m_addr[9:2]];
         end
      end
   end

   typedef struct {
      logic        ir;
      logic [31:0] ia;
      logic        dr;
      logic [3:0]  we;
      logic [31:0] da;
      logic [31:0] dw;
      logic        eig;
      logic        edg;
   } vec_t;

   typedef struct {
      logic        irv;
      logic        drv;
      logic [31:0] data;
   } rsp_t;

   rsp_t        sb[$];
   vec_t        tbl[$];
   logic [31:0] exp_ih, exp_dh;
   int          cmps = 0;
   int          errs = 0;

   function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic dr,
                               input logic [3:0] we, input logic [31:0] da, input logic [31:0] dw,
                               input logic eig, input logic edg);
      vec_t v;
      v.ir = ir; v.ia = ia; v.dr = dr; v.we = we; v.da = da; v.dw = dw;
      v.eig = eig; v.edg = edg;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      cmps++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Pop the response expected this cycle (none if queue empty) and check it
   task automatic check_rsp(input string nm);
      rsp_t e;
      e.irv = 1'b0; e.drv = 1'b0; e.data = 32'h0;
      if (sb.size() > 0) e = sb.pop_front();
      if (e.irv) exp_ih = e.data;
      if (e.drv) exp_dh = e.data;
      chk({nm, " i_rvalid"}, 32'(i_rvalid), 32'(e.irv));
      chk({nm, " d_rvalid"}, 32'(d_rvalid), 32'(e.drv));
      chk({nm, " i_rdata"},  i_rdata, exp_ih);
      chk({nm, " d_rdata"},  d_rdata, exp_dh);
   endtask

   // Entered at posedge+1; drives, checks at negedge, returns at next posedge+1
   task automatic cyc(input vec_t v, input string nm);
      rsp_t r;
      i_req = v.ir; i_addr = v.ia;
      d_req = v.dr; d_we = v.we; d_addr = v.da; d_wdata = v.dw;
      #4;
      check_rsp(nm);
      chk({nm, " i_gnt"},   32'(i_gnt), 32'(v.eig));
      chk({nm, " d_gnt"},   32'(d_gnt), 32'(v.edg));
      chk({nm, " m_en"},    32'(m_en),  32'(v.eig | v.edg));
      chk({nm, " m_addr"},  m_addr,  v.eig ? v.ia : (v.edg ? v.da : 32'h0));
      chk({nm, " m_we"},    32'(m_we), v.edg ? 32'(v.we) : 32'h0);
      chk({nm, " m_wdata"}, m_wdata, v.edg ? v.dw : 32'h0);
      r.irv  = v.eig;
      r.drv  = v.edg && (v.we == 4'h0);
      r.data = v.eig ? ref_mem[v.ia[9:2]] : ref_mem[v.da[9:2]];
      if (v.edg && v.we != 4'h0)
         for (int b = 0; b < 4; b++)
            if (v.we[b]) ref_mem[v.da[9:2]][8*b +: 8] = v.dw[8*b +: 8];
      sb.push_back(r);
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int k = 0; k < 256; k++) begin
         mem[k]     = 32'hC0DE0000 + k;
         ref_mem[k] = 32'hC0DE0000 + k;
      end
      mem[64]     = 32'hDEADBEEF;
      ref_mem[64] = 32'hDEADBEEF;
      exp_ih = 32'h0;
      exp_dh = 32'h0;

      // Requests high during reset must not produce grants
      reset = 1'b1;
      i_req = 1'b1; i_addr = 32'h100;
      d_req = 1'b1; d_we = 4'h0; d_addr = 32'h40; d_wdata = 32'h0;
      #2;
      chk("rst i_gnt",    32'(i_gnt), 32'h0);
      chk("rst d_gnt",    32'(d_gnt), 32'h0);
      chk("rst m_en",     32'(m_en), 32'h0);
      chk("rst m_addr",   m_addr, 32'h0);
      chk("rst i_rvalid", 32'(i_rvalid), 32'h0);
      chk("rst d_rvalid", 32'(d_rvalid), 32'h0);
      chk("rst i_rdata",  i_rdata, 32'h0);
      chk("rst d_rdata",  d_rdata, 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      tbl.push_back(mk(0, 32'h0,   0, 4'h0, 32'h0,  32'h0,        0, 0)); // idle
      tbl.push_back(mk(1, 32'h100, 0, 4'h0, 32'h0,  32'h0,        1, 0)); // fetch alone
      tbl.push_back(mk(0, 32'h0,   0, 4'h0, 32'h0,  32'h0,        0, 0)); // DEADBEEF returns
      tbl.push_back(mk(0, 32'h0,   0, 4'h0, 32'h0,  32'h0,        0, 0)); // held
      tbl.push_back(mk(0, 32'h0,   1, 4'hF, 32'h40, 32'h12345678, 0, 1)); // write
      tbl.push_back(mk(0, 32'h0,   1, 4'h0, 32'h40, 32'h0,        0, 1)); // read back
      tbl.push_back(mk(0, 32'h0,   0, 4'h0, 32'h0,  32'h0,        0, 0));
      for (int k = 0; k < 4; k++)                                          // contention
         tbl.push_back(mk(1, 32'h104, 1, 4'h0, 32'h44, 32'h0, 0, 1));
      tbl.push_back(mk(1, 32'h104, 1, 4'h0, 32'h44, 32'h0, 1, 0));
      tbl.push_back(mk(1, 32'h104, 1, 4'h0, 32'h44, 32'h0, 0, 1));
      tbl.push_back(mk(1, 32'h108, 0, 4'h0, 32'h0,  32'h0, 1, 0));
      tbl.push_back(mk(1, 32'h108, 1, 4'h0, 32'h48, 32'h0, 0, 1));
      tbl.push_back(mk(0, 32'h0,   1, 4'h3, 32'h40, 32'hFFFFAAAA, 0, 1)); // partial write
      tbl.push_back(mk(0, 32'h0,   1, 4'h0, 32'h40, 32'h0, 0, 1));
      tbl.push_back(mk(0, 32'h0,   0, 4'h0, 32'h0,  32'h0, 0, 0));
      for (int k = 0; k < 3; k++)
         tbl.push_back(mk(1, 32'h10C, 1, 4'h0, 32'h4C, 32'h0, 0, 1));
      tbl.push_back(mk(0, 32'h0, 1, 4'h0, 32'h4C, 32'h0, 0, 1));          // i_req drop clears
      for (int k = 0; k < 4; k++)
         tbl.push_back(mk(1, 32'h10C, 1, 4'h0, 32'h4C, 32'h0, 0, 1));
      tbl.push_back(mk(1, 32'h10C, 1, 4'h0, 32'h4C, 32'h0, 1, 0));
      tbl.push_back(mk(0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0, 0));

      foreach (tbl[n]) cyc(tbl[n], $sformatf("vec%0d", n));

      // Reset while a data read is in flight, with counter part-way up
      cyc(mk(1, 32'h110, 1, 4'h0, 32'h50, 32'h0, 0, 1), "pre_rst0");
      cyc(mk(1, 32'h110, 1, 4'h0, 32'h50, 32'h0, 0, 1), "pre_rst1");
      i_req = 1'b1; d_req = 1'b1; d_we = 4'h0; d_addr = 32'h54;
      #4;
      chk("midrd d_gnt", 32'(d_gnt), 32'h1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("inrst d_rvalid", 32'(d_rvalid), 32'h0);
      chk("inrst d_rdata",  d_rdata, 32'h0);
      chk("inrst i_rdata",  i_rdata, 32'h0);
      chk("inrst d_gnt",    32'(d_gnt), 32'h0);
      chk("inrst m_en",     32'(m_en), 32'h0);
      reset = 1'b0;
      sb.delete();
      exp_ih = 32'h0;
      exp_dh = 32'h0;
      // Counter restarted at 0: four data grants before fetch wins
      for (int k = 0; k < 4; k++)
         cyc(mk(1, 32'h110, 1, 4'h0, 32'h50, 32'h0, 0, 1), $sformatf("post_rst%0d", k));
      cyc(mk(1, 32'h110, 1, 4'h0, 32'h50, 32'h0, 1, 0), "post_rst4");
      cyc(mk(0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0, 0), "drain0");
      cyc(mk(0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0, 0), "drain1");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end

endmodule
